// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: walks every RO pair (a<b), times reset/measure/hold
// phases, compares the two edge counters and streams one bit per pair.
module ro_puf_sequencer #(
    parameter int NUM_RO = 16,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 12,
    parameter int IDX_W  = 7,
    parameter int SETTLE = 3,
    parameter int WINDOW = 4095,
    parameter int HOLD   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [SEL_W-1:0] sel_a_o,
    output logic [SEL_W-1:0] sel_b_o,
    output logic             ro_enable_o,
    output logic             ro_reset_o,
    input  logic [CNT_W-1:0] cnt_a_i,
    input  logic [CNT_W-1:0] cnt_b_i,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             bit_data_o,
    output logic [IDX_W-1:0] bit_index_o,
    output logic [7:0]       ties_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_MEAS,
        S_HLD,
        S_CMP,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_A = SEL_W'(NUM_RO - 2);
    localparam logic [SEL_W-1:0] LAST_B = SEL_W'(NUM_RO - 1);
    // RST spends one cycle letting the new selects settle through the
    // muxes, then SETTLE cycles of counter/RO reset.
    localparam logic [CNT_W-1:0] T_RST  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] T_MEAS = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] T_HLD  = CNT_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d;
    logic [7:0]       ties_q, ties_d;
    logic             en_q, rst_q, valid_q, busy_q, done_q;

    // Next-state, phase timer, pair walk and comparison
    always_comb begin
        state_d = state_q;
        tmr_d   = (tmr_q != '0) ? tmr_q - CNT_W'(1) : tmr_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        ties_d  = ties_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_RST;
                        tmr_d   = T_RST;
                        sel_a_d = '0;
                        sel_b_d = SEL_W'(1);
                        idx_d   = '0;
                        ties_d  = '0;
                    end
                end
                S_RST: begin
                    if (tmr_q == '0) begin
                        state_d = S_MEAS;
                        tmr_d   = T_MEAS;
                    end
                end
                S_MEAS: begin
                    if (tmr_q == '0) begin
                        state_d = S_HLD;
                        tmr_d   = T_HLD;
                    end
                end
                S_HLD: begin
                    if (tmr_q == '0) begin
                        state_d = S_CMP;
                    end
                end
                S_CMP: begin
                    state_d = S_EMIT;
                    bit_d   = (cnt_a_i > cnt_b_i);
                    if (cnt_a_i == cnt_b_i && ties_q != 8'hFF) begin
                        ties_d = ties_q + 8'd1;
                    end
                end
                S_EMIT: begin
                    if (valid_q && bit_ready_i) begin
                        if (sel_a_q == LAST_A && sel_b_q == LAST_B) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RST;
                            tmr_d   = T_RST;
                            idx_d   = idx_q + IDX_W'(1);
                            if (sel_b_q == LAST_B) begin
                                sel_a_d = sel_a_q + SEL_W'(1);
                                sel_b_d = sel_a_q + SEL_W'(2);
                            end else begin
                                sel_b_d = sel_b_q + SEL_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= SEL_W'(1);
            idx_q   <= '0;
            bit_q   <= 1'b0;
            ties_q  <= '0;
            en_q    <= 1'b0;
            rst_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            ties_q  <= ties_d;
            en_q    <= (state_d == S_MEAS);
            rst_q   <= (state_d == S_IDLE) || (state_d == S_RST) ||
                       (state_d == S_DONE);
            valid_q <= (state_d == S_EMIT);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign sel_a_o     = sel_a_q;
    assign sel_b_o     = sel_b_q;
    assign ro_enable_o = en_q;
    assign ro_reset_o  = rst_q;
    assign bit_valid_o = valid_q;
    assign bit_data_o  = bit_q;
    assign bit_index_o = idx_q;
    assign ties_o      = ties_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: random-rate RO sweeps against a pair-order and
// count-comparison model, plus directed timing, abort and reset cases.
module tb_ro_puf_sequencer;

    localparam int NUM_RO = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 12;
    localparam int IDX_W  = 7;
    localparam int SETTLE = 3;
    localparam int WINDOW = 16;
    localparam int HOLD   = 2;

    typedef struct {
        int idx;
        int a;
        int b;
        bit d;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             bit_ready = 1'b0;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             ro_enable, ro_reset;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             bit_valid, bit_data;
    logic [IDX_W-1:0] bit_index;
    logic [7:0]       ties;
    logic             busy, done;

    ro_puf_sequencer #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .IDX_W(IDX_W),
        .SETTLE(SETTLE), .WINDOW(WINDOW), .HOLD(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start), .abort_i(abort),
        .sel_a_o(sel_a), .sel_b_o(sel_b),
        .ro_enable_o(ro_enable), .ro_reset_o(ro_reset),
        .cnt_a_i(cnt_a), .cnt_b_i(cnt_b),
        .bit_valid_o(bit_valid), .bit_ready_i(bit_ready),
        .bit_data_o(bit_data), .bit_index_o(bit_index),
        .ties_o(ties), .busy_o(busy), .done_o(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RO edge counters: each RO adds its rate per enabled cycle
    int               rate [NUM_RO];
    bit               fixed_mode = 1'b0;
    int               fa = 0;
    int               fb = 0;
    logic [CNT_W-1:0] ca = '0;
    logic [CNT_W-1:0] cb = '0;

    always @(posedge clock) begin
        if (ro_reset) begin
            ca <= '0;
            cb <= '0;
        end else if (ro_enable) begin
            ca <= ca + CNT_W'(rate[sel_a]);
            cb <= cb + CNT_W'(rate[sel_b]);
        end
    end

    assign cnt_a = fixed_mode ? CNT_W'(fa) : ca;
    assign cnt_b = fixed_mode ? CNT_W'(fb) : cb;

    exp_t exp_q[$];
    int   exp_ties = 0;
    int   npass = 0;
    int   nchk = 0;
    bit   sweep_active = 1'b0;
    int   en_len = 0;
    int   en_runs = 0;
    int   gap = 0;
    int   rst_len = 0;
    int   done_cnt = 0;
    bit   prev_valid = 1'b0;
    bit   prev_en = 1'b0;
    bit   prev_rst = 1'b0;
    bit   prev_done = 1'b0;
    bit   popped_prev = 1'b0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)",
                      name, act, exp, cyc);
    endtask

    // Expected bit stream of one sweep: pairs in (a,b) order, counts
    // are rate*WINDOW, ties counted with saturation.
    task automatic plan_sweep();
        int k = 0;
        int t = 0;
        exp_q.delete();
        for (int a = 0; a < NUM_RO - 1; a++) begin
            for (int b = a + 1; b < NUM_RO; b++) begin
                int   va;
                int   vb;
                exp_t e;
                va    = fixed_mode ? fa : rate[a] * WINDOW;
                vb    = fixed_mode ? fb : rate[b] * WINDOW;
                e.idx = k;
                e.a   = a;
                e.b   = b;
                e.d   = (va > vb);
                exp_q.push_back(e);
                if (va == vb) t++;
                k++;
            end
        end
        exp_ties = (t > 255) ? 255 : t;
    endtask

    task automatic flush();
        exp_q.delete();
        sweep_active = 1'b0;
        en_len = 0;
        en_runs = 0;
        gap = 0;
        prev_valid = 1'b0;
        popped_prev = 1'b0;
        prev_done = 1'b0;
        prev_en = 1'b0;
        prev_rst = 1'b0;
    endtask

    // Per-cycle compare against the model and the stream rules
    always @(negedge clock) begin
        if (!reset) begin
            chk("sel_order", sel_a < sel_b, 1);
            if (!busy) chk("idle_outputs", {ro_reset, ro_enable, bit_valid}, 4);
            if (sweep_active && exp_q.size() > 0) chk("busy", busy, 1);
            if (ro_enable && !prev_en)
                chk("settle_before_window", prev_rst && rst_len >= SETTLE, 1);
            if (ro_enable) begin
                en_len++;
            end else if (en_len != 0) begin
                chk("window_len", en_len, WINDOW);
                en_runs++;
                gap = 0;
                en_len = 0;
            end else begin
                gap++;
            end
            rst_len  = ro_reset ? rst_len + 1 : 0;
            prev_rst = ro_reset;
            prev_en  = ro_enable;
            if (popped_prev) begin
                chk("valid_drops", bit_valid, 0);
                if (exp_q.size() == 0 && sweep_active) chk("done_pulse", done, 1);
            end
            popped_prev = 1'b0;
            if (bit_valid) begin
                if (!prev_valid) begin
                    chk("one_window_per_bit", en_runs, 1);
                    chk("hold_gap", gap, HOLD + 1);
                    en_runs = 0;
                end
                chk("no_enable_in_emit", ro_enable, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", bit_valid, 0);
                end else begin
                    chk("bit_index", bit_index, exp_q[0].idx);
                    chk("sel_a", sel_a, exp_q[0].a);
                    chk("sel_b", sel_b, exp_q[0].b);
                    chk("bit_data", bit_data, exp_q[0].d);
                    if (bit_ready) begin
                        void'(exp_q.pop_front());
                        popped_prev = 1'b1;
                    end
                end
            end
            prev_valid = bit_valid;
            if (done) begin
                chk("done_after_last", sweep_active && exp_q.size() == 0, 1);
                chk("ties_at_done", ties, exp_ties);
                chk("busy_with_done", busy, 1);
                done_cnt++;
                sweep_active = 1'b0;
            end
            if (prev_done) chk("done_single_cycle", {done, busy}, 0);
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset_vals();
        chk("rv_sel_a", sel_a, 0);
        chk("rv_sel_b", sel_b, 1);
        chk("rv_ro_enable", ro_enable, 0);
        chk("rv_ro_reset", ro_reset, 1);
        chk("rv_bit_valid", bit_valid, 0);
        chk("rv_bit_data", bit_data, 0);
        chk("rv_bit_index", bit_index, 0);
        chk("rv_ties", ties, 0);
        chk("rv_busy", busy, 0);
        chk("rv_done", done, 0);
    endtask

    task automatic chk_aborted();
        chk("abort_valid", bit_valid, 0);
        chk("abort_ro_reset", ro_reset, 1);
        chk("abort_ro_enable", ro_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
    endtask

    task automatic begin_sweep();
        plan_sweep();
        start = 1'b1;
        step();
        start = 1'b0;
        sweep_active = 1'b1;
        chk("start_ties_cleared", ties, 0);
        chk("start_busy", busy, 1);
        chk("start_first_pair", {sel_a, sel_b}, 1);
    endtask

    task automatic run_until_done(input int ready_pct, input bit poke,
                                  input bit hold5);
        int d0 = done_cnt;
        int n = 0;
        int held = 0;
        while (done_cnt == d0 && n < 8000) begin
            bit_ready = ($urandom_range(0, 99) < ready_pct);
            if (hold5 && exp_q.size() > 0 && exp_q[0].idx == 5 && held < 50) begin
                bit_ready = 1'b0;
                if (bit_valid) held++;
            end
            start = poke && exp_q.size() > 0 && ($urandom_range(0, 15) == 0);
            step();
            n++;
        end
        start = 1'b0;
        bit_ready = 1'b0;
        repeat (5) step();
        chk("single_done_per_sweep", done_cnt - d0, 1);
        if (hold5) chk("bit5_held_cycles", held, 50);
    endtask

    initial begin
        int first_en;
        int last_en;
        int first_v;
        bit found;
        for (int i = 0; i < NUM_RO; i++) rate[i] = 1;

        wait_edge(1);
        chk_reset_vals();
        reset = 1'b0;

        // Directed first-pair timing with fixed counts 200 vs 150
        fixed_mode = 1'b1;
        fa = 200;
        fb = 150;
        plan_sweep();
        wait_edge(9);
        start = 1'b1;
        step();
        start = 1'b0;
        sweep_active = 1'b1;
        chk("t1_ties_cleared", ties, 0);
        first_en = -1;
        last_en = -1;
        first_v = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (ro_enable) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (bit_valid && first_v < 0) first_v = cyc;
        end
        chk("t1_enable_first_edge", first_en, 14);
        chk("t1_enable_last_edge", last_en, 29);
        chk("t1_valid_edge", first_v, 33);
        chk("t1_bit_data", bit_data, 1);
        chk("t1_bit_index", bit_index, 0);
        chk("t1_sel_a", sel_a, 0);
        chk("t1_sel_b", sel_b, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        flush();
        chk_aborted();

        // Random-rate sweep, random ready, start pokes, bit 5 held off
        fixed_mode = 1'b0;
        for (int i = 0; i < NUM_RO; i++) rate[i] = $urandom_range(1, 15);
        begin_sweep();
        run_until_done(75, 1'b1, 1'b1);

        // Equal counts everywhere, three back-to-back sweeps
        for (int i = 0; i < NUM_RO; i++) rate[i] = 7;
        for (int s = 0; s < 3; s++) begin
            begin_sweep();
            run_until_done(100, 1'b0, 1'b0);
            chk("equal_sweep_ties", ties, 120);
        end

        // Abort during the measurement window of pair 7
        for (int i = 0; i < NUM_RO; i++) rate[i] = $urandom_range(1, 15);
        begin_sweep();
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            bit_ready = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].idx == 7 && ro_enable) found = 1'b1;
            else step();
        end
        chk("reached_pair7_meas", found, 1);
        first_v = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        flush();
        chk_aborted();
        repeat (60) step();
        chk("no_done_after_abort", done_cnt - first_v, 0);

        // Restart from index 0, then async reset while bit 3 is pending
        begin_sweep();
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            bit_ready = exp_q.size() > 0 && exp_q[0].idx < 3;
            if (exp_q.size() > 0 && exp_q[0].idx == 3 && bit_valid) begin
                found = 1'b1;
                start = 1'b0;
            end else begin
                start = ($urandom_range(0, 7) == 0);
                step();
            end
        end
        start = 1'b0;
        chk("reached_bit3_emit", found, 1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        flush();
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        chk_reset_vals();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
